// File: rtl/softex_lane_dispatch_pkg.sv
// Shared constants and chunk-to-lane mapping helpers for the softex lane
// dispatch and merge blocks.
package softex_lane_dispatch_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 256;
    localparam int unsigned DEF_NUM_LANES    = 4;
    localparam int unsigned DEF_ELEM_WIDTH   = 16;
    localparam int unsigned DEF_ELEM_STRIDE  = 4;
    localparam int unsigned DEF_FIFO_DEPTH   = 2;
    localparam int unsigned DEF_LANE_WIDTH   = DEF_DATA_WIDTH / DEF_NUM_LANES;
    localparam int unsigned LANE_ELEM_STRIDE = DEF_ELEM_STRIDE;

    // Chunk c is dealt round-robin: lane c mod num_lanes, slot c / num_lanes.
    function automatic int unsigned lane_of_chunk(input int unsigned c,
                                                  input int unsigned num_lanes);
        return c % num_lanes;
    endfunction

    function automatic int unsigned slot_of_chunk(input int unsigned c,
                                                  input int unsigned num_lanes);
        return c / num_lanes;
    endfunction

endpackage

// File: rtl/softex_lane_dispatch_fifo.sv
// Small per-lane circular FIFO with occupancy counter; depth need not be a
// power of two. Memory is cleared on flush so the head reads zero when empty.
module softex_lane_dispatch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign occupancy = occ;

endmodule

// File: rtl/softex_lane_dispatch.sv
// Deals fixed-stride element chunks of a wide input beat to NUM_LANES lane
// streams, each buffered by its own FIFO; input acceptance is all-or-nothing.
module softex_lane_dispatch
    import softex_lane_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned NUM_LANES   = DEF_NUM_LANES,
    parameter int unsigned ELEM_WIDTH  = DEF_ELEM_WIDTH,
    parameter int unsigned ELEM_STRIDE = DEF_ELEM_STRIDE,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                clear_i,
    input  logic [DATA_WIDTH-1:0]                               in_data_i,
    input  logic [DATA_WIDTH/8-1:0]                             in_strb_i,
    input  logic                                                in_valid_i,
    output logic                                                in_ready_o,
    output logic [NUM_LANES-1:0][DATA_WIDTH/NUM_LANES-1:0]      lane_data_o,
    output logic [NUM_LANES-1:0][DATA_WIDTH/NUM_LANES/8-1:0]    lane_strb_o,
    output logic [NUM_LANES-1:0]                                lane_valid_o,
    input  logic [NUM_LANES-1:0]                                lane_ready_i,
    output logic                                                idle_o
);

    localparam int unsigned LANE_WIDTH  = DATA_WIDTH / NUM_LANES;
    localparam int unsigned LANE_STRB   = LANE_WIDTH / 8;
    localparam int unsigned CHUNK_WIDTH = ELEM_WIDTH * ELEM_STRIDE;
    localparam int unsigned CHUNK_STRB  = CHUNK_WIDTH / 8;
    localparam int unsigned N_CHUNK     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned FIFO_WIDTH  = LANE_WIDTH + LANE_STRB;
    localparam int unsigned OCC_W       = $clog2(FIFO_DEPTH+1);

    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] slice_data;
    logic [NUM_LANES-1:0][LANE_STRB-1:0]  slice_strb;
    logic [NUM_LANES-1:0][OCC_W-1:0]      occ;
    logic                                 flush;
    logic                                 push;

    assign flush = rst_i | clear_i;
    assign push  = in_valid_i & in_ready_o;

    // Chunk slicing: strobes travel with their data bytes.
    for (genvar c = 0; c < N_CHUNK; c++) begin : g_chunk
        localparam int unsigned LANE = lane_of_chunk(c, NUM_LANES);
        localparam int unsigned SLOT = slot_of_chunk(c, NUM_LANES);
        assign slice_data[LANE][SLOT*CHUNK_WIDTH +: CHUNK_WIDTH] =
            in_data_i[c*CHUNK_WIDTH +: CHUNK_WIDTH];
        assign slice_strb[LANE][SLOT*CHUNK_STRB +: CHUNK_STRB] =
            in_strb_i[c*CHUNK_STRB +: CHUNK_STRB];
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [FIFO_WIDTH-1:0] head;

        softex_lane_dispatch_fifo #(
            .WIDTH (FIFO_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_i),
            .flush     (flush),
            .push      (push),
            .push_data ({slice_strb[k], slice_data[k]}),
            .pop       (lane_valid_o[k] & lane_ready_i[k]),
            .head_data (head),
            .occupancy (occ[k])
        );

        assign lane_valid_o[k] = (occ[k] != '0);
        assign lane_data_o[k]  = head[LANE_WIDTH-1:0];
        assign lane_strb_o[k]  = head[FIFO_WIDTH-1:LANE_WIDTH];
    end

    // Ready and idle depend only on registered occupancy.
    always_comb begin
        in_ready_o = 1'b1;
        idle_o     = 1'b1;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (occ[k] >= OCC_W'(FIFO_DEPTH)) begin
                in_ready_o = 1'b0;
            end
            if (occ[k] != '0) begin
                idle_o = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_softex_lane_dispatch.sv
// Self-checking bench for softex_lane_dispatch: vector table, lockstep lane
// scoreboard, stall/clear sequences and a two-lane mapping instance.
module tb_softex_lane_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, clear;
    logic                  in_valid;
    logic [255:0]          in_data;
    logic [31:0]           in_strb;
    logic                  in_ready;
    logic [3:0][63:0]      lane_data;
    logic [3:0][7:0]       lane_strb;
    logic [3:0]            lane_valid;
    logic [3:0]            lane_ready;
    logic                  idle;

    logic                  in_valid2;
    logic [255:0]          in_data2;
    logic [31:0]           in_strb2;
    logic                  in_ready2;
    logic [1:0][127:0]     lane_data2;
    logic [1:0][15:0]      lane_strb2;
    logic [1:0]            lane_valid2;
    logic [1:0]            lane_ready2;
    logic                  idle2;

    softex_lane_dispatch dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .in_data_i    (in_data),
        .in_strb_i    (in_strb),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .lane_data_o  (lane_data),
        .lane_strb_o  (lane_strb),
        .lane_valid_o (lane_valid),
        .lane_ready_i (lane_ready),
        .idle_o       (idle)
    );

    softex_lane_dispatch #(.NUM_LANES(2)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .in_data_i    (in_data2),
        .in_strb_i    (in_strb2),
        .in_valid_i   (in_valid2),
        .in_ready_o   (in_ready2),
        .lane_data_o  (lane_data2),
        .lane_strb_o  (lane_strb2),
        .lane_valid_o (lane_valid2),
        .lane_ready_i (lane_ready2),
        .idle_o       (idle2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  s;
    } ent_t;

    ent_t sb [4][$];

    typedef struct {
        logic [255:0]     d;
        logic [31:0]      s;
        logic [3:0][63:0] ed;
        logic [3:0][7:0]  es;
    } vec_t;

    vec_t vt [3];

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_slice_d(input logic [255:0] d, input int k, input int nl);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            if (c % nl == k) r[(c/nl)*64 +: 64] = d[c*64 +: 64];
        end
        return r;
    endfunction

    function automatic logic [15:0] model_slice_s(input logic [31:0] s, input int k, input int nl);
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            if (c % nl == k) r[(c/nl)*8 +: 8] = s[c*8 +: 8];
        end
        return r;
    endfunction

    function automatic bit model_ready();
        for (int k = 0; k < 4; k++) begin
            if (sb[k].size() >= 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_idle();
        for (int k = 0; k < 4; k++) begin
            if (sb[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("lane%0d_valid", k), 128'(lane_valid[k]), 128'(sb[k].size() != 0));
            if (sb[k].size() != 0) begin
                cmp($sformatf("lane%0d_data", k), 128'(lane_data[k]), 128'(sb[k][0].d));
                cmp($sformatf("lane%0d_strb", k), 128'(lane_strb[k]), 128'(sb[k][0].s));
            end
        end
        cmp("in_ready", 128'(in_ready), 128'(model_ready()));
        cmp("idle", 128'(idle), 128'(model_idle()));
    endtask

    // Model one clock edge with the currently driven inputs, then compare.
    task automatic tick();
        bit   rdy;
        ent_t e;
        rdy = model_ready();
        if (rst || clear) begin
            for (int k = 0; k < 4; k++) sb[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_ready[k] && sb[k].size() != 0) void'(sb[k].pop_front());
            end
            if (in_valid && rdy) begin
                for (int k = 0; k < 4; k++) begin
                    e.d = 64'(model_slice_d(in_data, k, 4));
                    e.s = 8'(model_slice_s(in_strb, k, 4));
                    sb[k].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_zero_lanes(input string tag);
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("%s_data%0d", tag, k), 128'(lane_data[k]), 128'(0));
            cmp($sformatf("%s_strb%0d", tag, k), 128'(lane_strb[k]), 128'(0));
        end
    endtask

    initial begin
        int bubbles;
        int accepted;
        int cyc;
        bit acc;

        vt[0].d = 256'h010f_010e_010d_010c_010b_010a_0109_0108_0107_0106_0105_0104_0103_0102_0101_0100;
        vt[0].s = 32'hffff_ffff;
        vt[0].ed[0] = 64'h0103_0102_0101_0100;
        vt[0].ed[1] = 64'h0107_0106_0105_0104;
        vt[0].ed[2] = 64'h010b_010a_0109_0108;
        vt[0].ed[3] = 64'h010f_010e_010d_010c;
        vt[0].es[0] = 8'hff; vt[0].es[1] = 8'hff; vt[0].es[2] = 8'hff; vt[0].es[3] = 8'hff;

        vt[1].d  = vt[0].d;
        vt[1].s  = 32'h0000_ffff;
        vt[1].ed = vt[0].ed;
        vt[1].es[0] = 8'hff; vt[1].es[1] = 8'hff; vt[1].es[2] = 8'h00; vt[1].es[3] = 8'h00;

        vt[2].d = ~vt[0].d;
        vt[2].s = 32'hf0f0_0f0f;
        vt[2].ed[0] = 64'hfefc_fefd_fefe_feff;
        vt[2].ed[1] = 64'hfef8_fef9_fefa_fefb;
        vt[2].ed[2] = 64'hfef4_fef5_fef6_fef7;
        vt[2].ed[3] = 64'hfef0_fef1_fef2_fef3;
        vt[2].es[0] = 8'h0f; vt[2].es[1] = 8'h0f; vt[2].es[2] = 8'hf0; vt[2].es[3] = 8'hf0;

        rst = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_data = '0; in_strb = '0; lane_ready = 4'hf;
        in_valid2 = 1'b0; in_data2 = '0; in_strb2 = '0; lane_ready2 = 2'b11;

        // Reset state
        tick();
        tick();
        check_zero_lanes("reset");
        rst = 1'b0;
        tick();

        // Mapping vectors, all lanes ready
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vt[i].d; in_strb = vt[i].s;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cmp($sformatf("vec%0d_data%0d", i, k), 128'(lane_data[k]), 128'(vt[i].ed[k]));
                cmp($sformatf("vec%0d_strb%0d", i, k), 128'(lane_strb[k]), 128'(vt[i].es[k]));
            end
            cmp($sformatf("vec%0d_valid", i), 128'(lane_valid), 128'(4'hf));
            tick();
        end

        // 100 back-to-back beats
        bubbles = 0;
        in_strb = '1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = rand256();
            if (!in_ready) bubbles++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        cmp("b2b_bubbles", 128'(bubbles), 128'(0));

        // Lane 2 stalled while streaming
        lane_ready = 4'b1011;
        in_valid = 1'b1; in_data = rand256();
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                accepted++;
                in_data = rand256();
            end
        end
        cmp("stall_accepted", 128'(accepted), 128'(2));
        cmp("stall_ready", 128'(in_ready), 128'(0));
        lane_ready = 4'hf;
        tick();
        cmp("resume_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Random valid and lane ready, 10k beats
        accepted = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (accepted < 10000 && cyc < 60000) begin
            lane_ready = 4'($urandom());
            if (!in_valid) begin
                in_valid = ($urandom() % 4) != 0;
                in_data  = rand256();
                in_strb  = $urandom();
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                accepted++;
                in_valid = 1'b0;
            end
        end
        cmp("random_beats", 128'(accepted), 128'(10000));
        in_valid = 1'b0; lane_ready = 4'hf;
        for (int i = 0; i < 3; i++) tick();

        // Clear with lanes full, then reset coinciding with a valid beat
        lane_ready = 4'h0;
        in_valid = 1'b1; in_data = rand256(); in_strb = '1;
        for (int i = 0; i < 4; i++) begin
            acc = in_ready;
            tick();
            if (acc) in_data = rand256();
        end
        cmp("full_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1; in_data = {16{16'hdead}};
        tick();
        cmp("rst_valid", 128'(lane_valid), 128'(0));
        cmp("rst_idle", 128'(idle), 128'(1));
        cmp("rst_ready", 128'(in_ready), 128'(1));
        check_zero_lanes("clear");
        rst = 1'b0; in_valid = 1'b0; lane_ready = 4'hf;
        tick();
        tick();
        cmp("dropped_beat", 128'(lane_valid), 128'(0));

        // Two-lane instance mapping
        in_valid2 = 1'b1; in_data2 = vt[0].d; in_strb2 = 32'h00ff_ff0f;
        tick();
        in_valid2 = 1'b0;
        cmp("nl2_valid", 128'(lane_valid2), 128'(2'b11));
        cmp("nl2_lane0", lane_data2[0], 128'h010b_010a_0109_0108_0103_0102_0101_0100);
        cmp("nl2_lane1", lane_data2[1], 128'h010f_010e_010d_010c_0107_0106_0105_0104);
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("nl2_model_data%0d", k), lane_data2[k], model_slice_d(in_data2, k, 2));
            cmp($sformatf("nl2_model_strb%0d", k), 128'(lane_strb2[k]), 128'(model_slice_s(in_strb2, k, 2)));
        end
        tick();
        cmp("nl2_drained", 128'(lane_valid2), 128'(0));
        cmp("nl2_idle", 128'(idle2), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
